counter_step_sched: RTL

- Scheduler that shares one 3-bit random counter (Moore FSM with enable/mode/sync reset; mode 0 steps 1→7→3→5→1, mode 1 steps 1→5→3→7→1) between NUM_REQ requesters.
- Each requester asks for a burst of N steps in its own mode, optionally restarting the counter at 1 first.
- The block grants requesters round-robin and drives the counter's reset/enable/mode for the burst.
- It returns the final count to the winning requester with a one-cycle done pulse.

---
 rtl/counter_step_sched_pkg.sv | 27 ++
 rtl/counter_step_sched_rr_arbiter.sv | 33 +++
 rtl/counter_step_sched.sv | 100 ++++++++++
 3 files changed

// File: rtl/counter_step_sched_pkg.sv
// Shared types and constants for the counter step scheduler and its 3-bit random counter.
package counter_step_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] CNT_ONE   = 3'b001;
    localparam logic [2:0] CNT_SEVEN = 3'b111;
    localparam logic [2:0] CNT_THREE = 3'b011;
    localparam logic [2:0] CNT_FIVE  = 3'b101;

    // Mode 0 walks 1-7-3-5, mode 1 walks 1-5-3-7; unreachable codes recover to 1.
    function automatic logic [2:0] cnt_next(input logic [2:0] cur, input logic mode);
        case (cur)
            CNT_ONE:   return mode ? CNT_FIVE  : CNT_SEVEN;
            CNT_SEVEN: return mode ? CNT_ONE   : CNT_THREE;
            CNT_THREE: return mode ? CNT_SEVEN : CNT_FIVE;
            CNT_FIVE:  return mode ? CNT_THREE : CNT_ONE;
            default:   return CNT_ONE;
        endcase
    endfunction

endpackage

// File: rtl/counter_step_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    int pos;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        index = '0;
        pos   = 0;
        // Scan from lowest priority to highest so the last hit wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            pos = (int'(ptr) + off) % NUM_REQ;
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                index      = IDX_W'(pos);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/counter_step_sched.sv
// Shares one 3-bit random counter between NUM_REQ requesters, running one burst at a time.
module counter_step_sched
    import counter_step_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LEN_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_mode,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ-1:0]       req_rst,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [2:0]               result,
    output logic                     busy,
    output logic                     cnt_reset,
    output logic                     cnt_enable,
    output logic                     cnt_mode,
    input  logic [2:0]               cnt_value
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   ptr;
    logic               mode_q;
    logic [LEN_W-1:0]   remaining;
    logic [2:0]         result_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_index;
    logic               arb_valid;
    logic [LEN_W-1:0]   sel_len;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req  (req),
        .ptr  (ptr),
        .grant(arb_grant),
        .index(arb_index),
        .valid(arb_valid)
    );

    assign sel_len = req_len[int'(arb_index)*LEN_W +: LEN_W];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            ptr       <= '0;
            mode_q    <= 1'b0;
            remaining <= '0;
            result_q  <= 3'b000;
        end else begin
            case (state)
                ST_IDLE: if (arb_valid) begin
                    owner     <= arb_index;
                    mode_q    <= req_mode[arb_index];
                    remaining <= sel_len;
                    ptr       <= (int'(arb_index) == NUM_REQ - 1) ? '0 : arb_index + 1'b1;
                    // A zero-length burst skips both clear and run, even with rst set.
                    if (sel_len == '0)           state <= ST_DONE;
                    else if (req_rst[arb_index]) state <= ST_CLEAR;
                    else                         state <= ST_RUN;
                end
                ST_CLEAR: state <= ST_RUN;
                ST_RUN: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_W'(1)) state <= ST_DONE;
                end
                ST_DONE: begin
                    result_q <= cnt_value;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        if (!reset && state == ST_IDLE) gnt         = arb_grant;
        if (!reset && state == ST_DONE) done[owner] = 1'b1;
    end

    // Counter already holds the final step during DONE, so result is valid alongside done.
    assign result     = (!reset && state == ST_DONE) ? cnt_value : result_q;
    assign busy       = (state != ST_IDLE);
    assign cnt_reset  = reset | (state == ST_CLEAR);
    assign cnt_enable = !reset && (state == ST_RUN);
    assign cnt_mode   = (state == ST_RUN) & mode_q;

endmodule
